// File: rtl/iir_mac_scheduler.sv
// Round-robin scheduler sharing one 4x4 signed multiplier among NCH comb-IIR
// channels, y[n] = COEF*x[n] + y[n-4], with per-channel 4-deep history.
module iir_mac_scheduler #(
    parameter int               NCH  = 4,
    parameter logic signed [3:0] COEF = 4'sb0111,
    localparam int              CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   req_valid,
    input  logic [4*NCH-1:0] req_x,
    output logic [NCH-1:0]   req_ready,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [7:0]       out_y,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              ptr_q;
    logic [CW-1:0]              gch_q;
    logic [3:0]                 x_q;
    logic [7:0]                 y_q;
    logic [CW-1:0]              ch_q;
    logic                       vld_q;
    logic [NCH-1:0][3:0][7:0]   hist_q;

    logic [NCH-1:0] elig;
    logic           found;
    logic [CW-1:0]  gnt;
    logic [CW-1:0]  idx;
    logic [7:0]     y_sum;

    // Search ptr+1 upward with wrap; ptr itself is checked last.
    always_comb begin
        elig  = req_valid & ch_en;
        found = 1'b0;
        gnt   = ptr_q;
        idx   = ptr_q;
        for (int i = 1; i <= NCH; i++) begin
            idx = ptr_q + CW'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        y_sum     = hist_q[gch_q][3] + mul_p;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // Gated so nothing is offered while reset is held.
                    req_ready[gnt] = rst;
                    state_d        = MUL;
                end
            end
            MUL: begin
                mul_a   = COEF;
                mul_b   = x_q;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= CW'(NCH - 1);
            gch_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                x_q   <= req_x[{gnt, 2'b00} +: 4];
                gch_q <= gnt;
                ptr_q <= gnt;
            end
            if (state_q == MUL) begin
                y_q   <= y_sum;
                ch_q  <= gch_q;
                vld_q <= 1'b1;
                if (ch_en[gch_q])
                    hist_q[gch_q] <= {hist_q[gch_q][2:0], y_sum};
            end
            if (state_q == OUT && out_ready)
                vld_q <= 1'b0;
            // A disabled channel's history is held at zero, overriding writes.
            for (int c = 0; c < NCH; c++) begin
                if (!ch_en[c]) hist_q[c] <= '0;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_ch    = ch_q;
    assign out_y     = y_q;

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed bench for iir_mac_scheduler with a behavioural signed multiplier
// and hand-computed comb-IIR results.
module tb_iir_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ch_en = '1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_x = '0;
    logic [3:0]  req_ready;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [7:0]  out_y;
    logic        out_ready = 1'b1;

    int errs  = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign mul_p = $signed({{4{mul_a[3]}}, mul_a}) *
                   $signed({{4{mul_b[3]}}, mul_b});

    iir_mac_scheduler #(.NCH(4), .COEF(4'sb0111)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_y     (out_y),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        req_valid = '0;
        ch_en     = '1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Starts and (with out_ready high) ends one cycle after a rising edge.
    task automatic xfer(input int ch, input logic [3:0] x,
                        input logic [7:0] ey);
        int n;
        n = 0;
        req_x[4*ch +: 4] = x;
        req_valid[ch]    = 1'b1;
        #1;
        while (!req_ready[ch] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1 << ch));
        @(posedge clk);
        #1 req_valid[ch] = 1'b0;
        chk("mul_a", 32'(mul_a), 32'd7);
        chk("mul_b", 32'(mul_b), 32'(x));
        chk("lat_mul_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_ch", 32'(out_ch), 32'(ch));
        chk("out_y", 32'(out_y), 32'(ey));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int o;
        int cnt [4];

        // Reset values, with requests pending while reset is held
        req_valid = '1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(out_y), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);

        // Impulse on channel 0
        do_reset;
        for (int i = 0; i < 8; i++)
            xfer(0, (i % 4 == 0) ? 4'd1 : 4'd0,
                 (i == 0) ? 8'd7 : (i == 4) ? 8'd14 : 8'd0);

        // Round-robin with all channels requesting x=1
        do_reset;
        req_x     = 16'h1111;
        req_valid = '1;
        g = 0;
        o = 0;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        #1;
        for (int cyc = 0; cyc < 200 && o < 20; cyc++) begin
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
                g++;
            end
            if (out_valid) begin
                chk("rr_ch", 32'(out_ch), 32'(o % 4));
                chk("rr_y", 32'(out_y), 32'(7 * (cnt[o % 4] / 4 + 1)));
                cnt[o % 4]++;
                o++;
            end
            @(posedge clk);
            #2;
        end
        chk("rr_count", 32'(o), 32'd20);
        req_valid = '0;

        // Wrap-around on channel 1 with x=-8
        do_reset;
        for (int i = 0; i < 9; i++)
            xfer(1, 4'h8, (i < 4) ? 8'hC8 : (i < 8) ? 8'h90 : 8'h58);

        // Backpressure in OUT
        do_reset;
        out_ready = 1'b0;
        xfer(3, 4'd2, 8'd14);
        req_x[3:0]   = 4'd1;
        req_valid[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_y", 32'(out_y), 32'd14);
            chk("bp_ch", 32'(out_ch), 32'd3);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_mul_a", 32'(mul_a), 32'd0);
            chk("bp_mul_b", 32'(mul_b), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_next_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_next_y", 32'(out_y), 32'd7);
        chk("bp_next_ch", 32'(out_ch), 32'd0);

        // Enable mask clears channel 2 history
        do_reset;
        repeat (4) xfer(2, 4'd1, 8'd7);
        ch_en        = 4'b1011;
        req_x[11:8]  = 4'd1;
        req_valid[2] = 1'b1;
        #1;
        chk("en_no_grant", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        ch_en     = '1;
        req_valid = '0;
        xfer(2, 4'd1, 8'd7);

        // Asynchronous reset during MUL
        do_reset;
        repeat (4) xfer(0, 4'd1, 8'd7);
        req_x[3:0]   = 4'd1;
        req_valid[0] = 1'b1;
        #1;
        chk("ar_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("ar_mul_a", 32'(mul_a), 32'd7);
        #1 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_mul_a0", 32'(mul_a), 32'd0);
        chk("ar_mul_b0", 32'(mul_b), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("ar_hold_valid", 32'(out_valid), 32'd0);
        rst       = 1'b1;
        req_x     = 16'h0011;
        req_valid = 4'b0011;
        #1;
        chk("ar_first_ch0", 32'(req_ready), 32'd1);
        req_valid = '0;
        xfer(0, 4'd1, 8'd7);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule

// File: doc/iir_mac_scheduler.md
# iir_mac_scheduler

Time-shares one external 4x4 signed Baugh-Wooley multiplier among NCH independent comb-IIR channels, each computing y[n] = COEF*x[n] + y[n-4]. Requesters present samples on valid/ready ports. The scheduler grants one channel at a time, round-robin, and drives the shared multiplier. It keeps a 4-deep output history per channel and returns each result with its channel tag over a valid/ready output port.

## Interface
- NCH, 4: number of channels (power of two, 2..8)
- COEF, 4'sb0111: signed 4-bit feed-forward coefficient, driven on mul_a
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- ch_en  in  NCH  per-channel enable mask
- req_valid  in  NCH  channel c has a sample on req_x[4c+3:4c]
- req_x  in  4*NCH  signed 4-bit samples, packed
- req_ready  out  NCH  one-hot; sample of channel c is accepted in a cycle when req_valid[c] && req_ready[c]
- mul_a  out  4  multiplier operand A (signed)
- mul_b  out  4  multiplier operand B (signed)
- mul_p  in  8  signed product from the multiplier, combinational from mul_a/mul_b
- out_valid  out  1  result available
- out_ch  out  log2(NCH)  channel of the result
- out_y  out  8  signed result y[n]
- out_ready  in  1  consumer accepts the result when out_valid && out_ready

## Operation
- FSM states:
  - IDLE: arbitrate.
  - MUL: one cycle, uses the multiplier.
  - OUT: result held until accepted.
- IDLE:
  - Eligible set = req_valid & ch_en.
  - Grant g = first eligible channel searching from ptr+1 upward, with wrap.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge: x_reg<=sample of g, gch<=g, ptr<=g, go to MUL.
  - If the eligible set is empty, stay in IDLE with req_ready=0.
- MUL:
  - mul_a=COEF, mul_b=x_reg.
  - y = hist[gch][3] + mul_p, as an 8-bit two's-complement sum that wraps mod 256 (no saturation).
  - On the edge: out_y<=y, out_ch<=gch, out_valid<=1, and shift that channel's history (hist[gch][0]<=y, hist[gch][k]<=hist[gch][k-1]). Go to OUT.
- OUT: hold out_y, out_ch and out_valid stable. On out_ready=1: out_valid<=0, go to IDLE.
- Outside MUL, mul_a=mul_b=0.
- Histories of other channels are never touched by a grant.
- ch_en[c]=0:
  - channel c is never granted;
  - its four history entries clear to 0 on every clock edge while it is low;
  - if c is the in-flight channel, the current MUL/OUT still completes and its history write is suppressed.
- Product range for COEF=7: -56..+49. Extending the 8-bit product by sign is not needed.

## Timing
- Reset (rst=0, async): state=IDLE, ptr=NCH-1 so channel 0 has first priority, all hist=0, x_reg=0, gch=0. Outputs: out_valid=0, out_y=0, out_ch=0, req_ready=0, mul_a=mul_b=0.
- Reset mid-transaction drops the in-flight sample and result. No output handshake completes.
- Latency: accept edge (IDLE) -> MUL edge -> out_valid=1 in the cycle after MUL, i.e. 2 cycles from acceptance to out_valid.
- Throughput with out_ready held high: one sample per 3 cycles (IDLE, MUL, OUT).
- out_ready low: FSM stays in OUT indefinitely. req_ready stays 0 for all channels and no history changes.
- req_valid dropping while not granted has no effect. A sample is taken only on an accepting edge.
- Simultaneous requests are served in round-robin order. No channel waits more than NCH grants.
- Deassertion of ch_en takes effect at the next IDLE arbitration.
- out_ready is not sampled outside OUT.

## Test plan
- Impulse, channel 0 only, out_ready=1: x = 1,0,0,0,1,0,0,0 -> out_y = 7,0,0,0,14,0,0,0, all with out_ch=0, each 2 cycles after acceptance.
- Round-robin: all 4 req_valid held high with x=1 each -> grant order 0,1,2,3,0,1. Each channel's first output is 7 and its fifth is 14; the 1-hot req_ready never has two bits set.
- Wrap: channel 1 fed x=-8 continuously -> outputs -56 four times, then -112 four times, then 88 (i.e. -168 mod 256).
- Backpressure: out_ready=0 for 5 cycles during OUT -> out_y and out_ch stable, req_ready=0, mul_a=mul_b=0. The next grant occurs the cycle after out_ready rises and the FSM returns to IDLE.
- Enable mask: after channel 2 has history 7,7,7,7, drop ch_en[2] for one cycle and re-enable it, then send x=1 -> out_y=7 (history cleared). Channel 2 is never granted while ch_en[2]=0.
- Async reset: assert rst low during MUL -> out_valid, req_ready and mul_* go 0 immediately with no result emitted. After release, channel 0 is served first and all channels start from zero history.
